// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared sample/peak widths, window FSM states and magnitude scaling
package scope_pkg;

    localparam int SAMPLE_W = 12;
    localparam int PEAK_W   = 12;

    // FILL: collecting a window. EMIT: the single cycle carrying a column.
    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } win_state_t;

    // |s| doubled and saturated to the 12-bit peak range.
    // -2048 has magnitude 2048, which is the only value with bit 11 set
    // after negation; any magnitude >= 2048 saturates to 4095.
    function automatic logic [PEAK_W-1:0] abs_scale12(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] mag;
        mag = s[SAMPLE_W-1] ? (~s + SAMPLE_W'(1)) : s;
        if (mag[SAMPLE_W-1]) begin
            return '1;
        end
        return {mag[SAMPLE_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/peak_hold_decay.sv
// rtl/peak_hold_decay.sv - peak-hold register with exponential decay
//
// Ports:
//   data_clk  clock, rising edge
//   reset_n   synchronous active-low reset
//   clear     synchronous clear of the hold register (run control low)
//   strobe    window close; result is captured into hold
//   wp        peak of the window being closed
//   result    combinational column value: wp, or max(wp, decayed hold)
//   hold      current hold level
module peak_hold_decay
    import scope_pkg::*;
#(
    parameter int DECAY_SHIFT = 4
) (
    input  logic              data_clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              strobe,
    input  logic [PEAK_W-1:0] wp,
    output logic [PEAK_W-1:0] result,
    output logic [PEAK_W-1:0] hold
);

    logic [PEAK_W-1:0] decayed;

    // hold>>DECAY_SHIFT never exceeds hold, so this cannot underflow.
    // Small holds shift to 0 and stop decaying; that floor is intended.
    assign decayed = hold - (hold >> DECAY_SHIFT);

    always_comb begin
        result = wp;
        if (DECAY_SHIFT != 0 && decayed > wp) begin
            result = decayed;
        end
    end

    always_ff @(posedge data_clk) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (clear) begin
            hold <= '0;
        end else if (strobe && DECAY_SHIFT != 0) begin
            hold <= result;
        end
    end

endmodule

// File: rtl/peak_window_source.sv
// rtl/peak_window_source.sv - reduces WINDOW accepted ADC samples to one peak column strobe
//
// Ports:
//   data_clk      clock, rising edge
//   reset_n       synchronous active-low reset
//   enable        run control; low clears window and hold state
//   sample_data   signed 12-bit ADC sample
//   sample_valid  sample_data is accepted when enable is also high
//   source_data   unsigned scaled peak of the last closed window (held)
//   source_valid  one-cycle strobe per closed window
//   overrange     sticky: a full-scale sample (-2048 or +2047) was accepted
module peak_window_source
    import scope_pkg::*;
#(
    parameter int WINDOW      = 1024,
    parameter int CNT_W       = 16,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                data_clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic [PEAK_W-1:0]   source_data,
    output logic                source_valid,
    output logic                overrange
);

    localparam logic [CNT_W-1:0]    LAST     = CNT_W'(WINDOW - 1);
    localparam logic [SAMPLE_W-1:0] FS_NEG   = 12'h800;
    localparam logic [SAMPLE_W-1:0] FS_POS   = 12'h7FF;

    win_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [PEAK_W-1:0] win_peak;
    logic [PEAK_W-1:0] scaled;
    logic [PEAK_W-1:0] peak_next;
    logic [PEAK_W-1:0] result;
    logic [PEAK_W-1:0] unused_hold;
    logic              accept;
    logic              closing;

    assign accept  = enable & sample_valid;
    assign closing = accept && (count == LAST);
    assign scaled  = abs_scale12(sample_data);

    // The first sample of a window loads directly so the previous window's
    // peak never leaks forward. On the closing sample this is the window peak.
    assign peak_next = (count == '0 || scaled > win_peak) ? scaled : win_peak;

    // Hold level is visible on the sub-module for probing; the column value
    // is all the display needs.
    peak_hold_decay #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_hold (
        .data_clk (data_clk),
        .reset_n  (reset_n),
        .clear    (~enable),
        .strobe   (closing),
        .wp       (peak_next),
        .result   (result),
        .hold     (unused_hold)
    );

    always_ff @(posedge data_clk) begin
        if (!reset_n) begin
            state        <= FILL;
            count        <= '0;
            win_peak     <= '0;
            source_data  <= '0;
            source_valid <= 1'b0;
            overrange    <= 1'b0;
        end else begin
            source_valid <= 1'b0;

            if (accept && (sample_data == FS_NEG || sample_data == FS_POS)) begin
                overrange <= 1'b1;
            end

            if (!enable) begin
                count    <= '0;
                win_peak <= '0;
            end else if (accept) begin
                win_peak <= peak_next;
                count    <= closing ? '0 : count + CNT_W'(1);
            end

            // Accumulation continues during EMIT; since WINDOW >= 2 and the
            // count has just wrapped, a close cannot land in the EMIT cycle.
            case (state)
                FILL: begin
                    if (closing) begin
                        state        <= EMIT;
                        source_valid <= 1'b1;
                        source_data  <= result;
                    end
                end
                EMIT: begin
                    state <= FILL;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peak_window_source.sv
// tb/tb_peak_window_source.sv - self-checking bench for peak_window_source
module tb_peak_window_source;

    localparam int WIN = 4;

    logic        data_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        sample_valid;
    logic [11:0] sample_data;

    logic [11:0] d0, d4;
    logic        v0, v4, o0, o4;

    always #5 data_clk = ~data_clk;

    peak_window_source #(.WINDOW(WIN), .CNT_W(3), .DECAY_SHIFT(0)) dut0 (
        .data_clk     (data_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .source_data  (d0),
        .source_valid (v0),
        .overrange    (o0)
    );

    peak_window_source #(.WINDOW(WIN), .CNT_W(3), .DECAY_SHIFT(4)) dut4 (
        .data_clk     (data_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .source_data  (d4),
        .source_valid (v4),
        .overrange    (o4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current window as a list of scaled magnitudes.
    int win_q[$];
    int m_hold;
    int m_d0, m_d4;
    bit m_v, m_ovr;

    function automatic int scale(input int d);
        int m;
        m = (d < 0) ? -d : d;
        return (2 * m > 4095) ? 4095 : 2 * m;
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input int d);
        int wp;
        int dec;
        @(negedge data_clk);
        reset_n      = r;
        enable       = e;
        sample_valid = v;
        sample_data  = 12'(d);
        @(posedge data_clk);
        #1;
        m_v = 1'b0;
        if (!r) begin
            win_q.delete();
            m_hold = 0; m_ovr = 1'b0; m_d0 = 0; m_d4 = 0;
        end else if (!e) begin
            win_q.delete();
            m_hold = 0;
        end else if (v) begin
            if (d == -2048 || d == 2047) m_ovr = 1'b1;
            win_q.push_back(scale(d));
            if (win_q.size() == WIN) begin
                wp = 0;
                foreach (win_q[i]) if (win_q[i] > wp) wp = win_q[i];
                dec    = m_hold - m_hold / 16;
                m_d0   = wp;
                m_d4   = (wp > dec) ? wp : dec;
                m_hold = m_d4;
                m_v    = 1'b1;
                win_q.delete();
            end
        end
        check("model_valid0", int'(v0), int'(m_v));
        check("model_valid4", int'(v4), int'(m_v));
        check("model_data0",  int'(d0), m_d0);
        check("model_data4",  int'(d4), m_d4);
        check("model_ovr0",   int'(o0), int'(m_ovr));
        check("model_ovr4",   int'(o4), int'(m_ovr));
    endtask

    typedef struct {
        bit r, e, v;
        int d;
        bit xv;
        int xd0, xd4;
        bit xo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit e, bit v, int d, bit xv, int xd0, int xd4, bit xo);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.d = d;
        t.xv = xv; t.xd0 = xd0; t.xd4 = xd4; t.xo = xo;
        return t;
    endfunction

    initial begin
        int pulses;
        reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;

        // Hand-derived vectors: reset, basic window, overrange, decay chain.
        tbl.push_back(mk(0, 1, 1,  123, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 1,   10, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 1, -300, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 1,    5, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 1,    7, 1,  600,  600, 0));
        tbl.push_back(mk(1, 1, 0,  999, 0,  600,  600, 0));
        tbl.push_back(mk(1, 1, 1, -2048, 0, 600,  600, 1));
        tbl.push_back(mk(1, 1, 1,    0, 0,  600,  600, 1));
        tbl.push_back(mk(1, 1, 1,    0, 0,  600,  600, 1));
        tbl.push_back(mk(1, 1, 1,    0, 1, 4095, 4095, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 4095, 4095, 1));
        tbl.push_back(mk(1, 1, 1,    0, 1,    0, 3840, 1));
        tbl.push_back(mk(1, 0, 1,  500, 0,    0, 3840, 1));
        tbl.push_back(mk(1, 1, 1,  800, 0,    0, 3840, 1));
        tbl.push_back(mk(1, 1, 1,    0, 0,    0, 3840, 1));
        tbl.push_back(mk(1, 1, 1,    0, 0,    0, 3840, 1));
        tbl.push_back(mk(1, 1, 1,    0, 1, 1600, 1600, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 1600, 1600, 1));
        tbl.push_back(mk(1, 1, 1,    0, 1,    0, 1500, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1500, 1));
        tbl.push_back(mk(1, 1, 1,    0, 1,    0, 1407, 1));
        tbl.push_back(mk(1, 1, 1, 2000, 0,    0, 1407, 1));
        tbl.push_back(mk(1, 1, 1,    0, 0,    0, 1407, 1));
        tbl.push_back(mk(1, 1, 1,    0, 0,    0, 1407, 1));
        tbl.push_back(mk(1, 1, 1,    0, 1, 4000, 4000, 1));
        tbl.push_back(mk(1, 1, 1,    1, 0, 4000, 4000, 1));
        tbl.push_back(mk(1, 1, 1,    2, 0, 4000, 4000, 1));
        tbl.push_back(mk(1, 1, 1,    3, 0, 4000, 4000, 1));
        tbl.push_back(mk(1, 1, 1, 2047, 1, 4094, 4094, 1));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
            check("tbl_valid0", int'(v0), int'(tbl[i].xv));
            check("tbl_valid4", int'(v4), int'(tbl[i].xv));
            check("tbl_data0",  int'(d0), tbl[i].xd0);
            check("tbl_data4",  int'(d4), tbl[i].xd4);
            check("tbl_ovr0",   int'(o0), int'(tbl[i].xo));
            check("tbl_ovr4",   int'(o4), int'(tbl[i].xo));
        end

        // sample_valid gaps: pulse only after the 4th accepted sample.
        step(0, 1, 0, 0);
        begin
            bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++) begin
                step(1, 1, pat[i], 100 * (i + 1));
                check("gap_pulse", int'(v0), (i == 6) ? 1 : 0);
            end
            check("gap_data", int'(d0), 1400);
        end

        // Back-to-back windows: the sample taken while valid is high starts the next window.
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 10 * (i + 1));
            check("b2b_pulse", int'(v0), (i == 3 || i == 7) ? 1 : 0);
        end
        check("b2b_data", int'(d0), 160);

        // Reset mid-window discards the partial window.
        step(1, 1, 1, 900);
        step(1, 1, 1, 900);
        step(0, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 50);
            if (v0) pulses++;
            check("rst_pulse", int'(v0), (i == 3) ? 1 : 0);
        end
        check("rst_data4", int'(d4), 100);

        // Enable low mid-window: no pulse, data retained, hold cleared.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1000);
        step(1, 0, 1, 1000);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 30);
            check("en_pulse", int'(v0), (i == 3) ? 1 : 0);
            check("en_data0", int'(d0), (i == 3) ? 60 : 100);
        end
        check("en_hold_cleared", int'(d4), 60);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, v;
            int d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 29) != 0);
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0:       d = -2048;
                1:       d = 2047;
                2:       d = 0;
                default: d = int'($urandom_range(0, 4095)) - 2048;
            endcase
            step(r, e, v, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
